// File: rtl/multirate_seq_ctrl_pkg.sv
// Shared types and default widths for the multi-rate capture/decode/multiply sequencer.
package mrs_pkg;

  localparam int MRS_DIV_W = 4;
  localparam int MRS_CNT_W = 8;

  // Sequencer state (2-bit encoding)
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } mrs_state_t;

endpackage

// File: rtl/multirate_seq_ctrl_rate_div.sv
// Programmable divide-by-(ratio+1) tick generator in the fast clock domain.
// The shadow ratio only changes at a period boundary, so a mid-period update
// of div_ratio takes effect from the following period.
module rate_div
  import mrs_pkg::*;
#(
  parameter int DIV_W = MRS_DIV_W
) (
  input  logic             fast_clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] div_ratio,
  output logic             slow_tick
);

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] r_count;
  logic [DIV_W-1:0] r_ratio_sh;
  logic             w_wrap;

  assign w_wrap    = (r_count == r_ratio_sh);
  assign slow_tick = run & w_wrap;

  // Count 0..ratio_sh while running; while stopped hold the count at 0 and
  // track div_ratio so the value seen on leaving IDLE sets the first period.
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_ratio_sh <= '0;
    end else if (!run) begin
      r_count    <= '0;
      r_ratio_sh <= div_ratio;
    end else if (w_wrap) begin
      r_count    <= '0;
      r_ratio_sh <= div_ratio;
    end else begin
      r_count    <= r_count + ONE;
    end
  end

endmodule

// File: rtl/multirate_seq_ctrl.sv
// Sequencer for the fast/slow capture-decode-multiply datapath: accepts words
// by valid/ready, advances them one stage per slow tick and drains cleanly.
//
//   state | meaning
//   IDLE  | stopped, divider held at 0, no ticks, no accepts
//   RUN   | ticking, accepting words into the hold (shift) stage
//   DRAIN | ticking, no accepts, waiting for hold/synch/decode to empty
module multirate_seq_ctrl
  import mrs_pkg::*;
#(
  parameter int DIV_W = MRS_DIV_W,
  parameter int CNT_W = MRS_CNT_W
) (
  input  logic             fast_clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             shift_en,
  output logic             slow_tick,
  output logic             synch_en,
  output logic             decode_en,
  output logic             mult_en,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  mrs_state_t       r_state;
  mrs_state_t       w_state_nxt;
  logic             r_hold_v;
  logic             r_v_sync;
  logic             r_v_dec;
  logic             r_v_mul;
  logic [CNT_W-1:0] r_done_cnt;
  logic             w_run;
  logic             w_tick;
  logic             w_accept;
  logic             w_drain_done;

  assign w_run = (r_state != IDLE);

  rate_div #(
    .DIV_W(DIV_W)
  ) u_rate_div (
    .fast_clk (fast_clk),
    .rst_n    (rst_n),
    .run      (w_run),
    .div_ratio(div_ratio),
    .slow_tick(w_tick)
  );

  assign slow_tick = w_tick;
  assign in_ready  = (r_state == RUN) & (~r_hold_v | w_tick);
  assign w_accept  = in_valid & in_ready;
  assign shift_en  = w_accept;
  assign synch_en  = w_tick & r_hold_v;
  assign decode_en = w_tick & r_v_sync;
  assign mult_en   = w_tick & r_v_dec;
  assign out_valid = r_v_mul;
  assign busy      = w_run;
  assign done_cnt  = r_done_cnt;

  // Drain finishes when nothing is left upstream of multiply, either already
  // or right after this tick moves the last word (in decode) into multiply.
  assign w_drain_done = ~(r_hold_v | r_v_sync | r_v_dec) |
                        (w_tick & ~r_hold_v & ~r_v_sync);

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable) w_state_nxt = RUN;
      RUN:     if (!enable) w_state_nxt = DRAIN;
      DRAIN: begin
        if (enable)            w_state_nxt = RUN;
        else if (w_drain_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Stage occupancy: shift one place per tick; the hold stage keeps its word
  // between ticks and on a tick is refilled only by this cycle's accept.
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_v <= 1'b0;
      r_v_sync <= 1'b0;
      r_v_dec  <= 1'b0;
      r_v_mul  <= 1'b0;
    end else if (w_tick) begin
      r_hold_v <= w_accept;
      r_v_sync <= r_hold_v;
      r_v_dec  <= r_v_sync;
      r_v_mul  <= r_v_dec;
    end else begin
      r_hold_v <= r_hold_v | w_accept;
    end
  end

  // Completed-word counter, wraps
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n)       r_done_cnt <= '0;
    else if (mult_en) r_done_cnt <= r_done_cnt + CNT_ONE;
  end

endmodule

// File: tb/tb_multirate_seq_ctrl.sv
// Directed bench for multirate_seq_ctrl with hand-derived per-cycle expectations.
module tb_multirate_seq_ctrl;

  logic       fast_clk;
  logic       rst_n;
  logic       enable;
  logic [3:0] div_ratio;
  logic       in_valid;
  logic       in_ready;
  logic       shift_en;
  logic       slow_tick;
  logic       synch_en;
  logic       decode_en;
  logic       mult_en;
  logic       out_valid;
  logic       busy;
  logic [7:0] done_cnt;

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;

  multirate_seq_ctrl #(.DIV_W(4), .CNT_W(8)) dut (
    .fast_clk (fast_clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .div_ratio(div_ratio),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .shift_en (shift_en),
    .slow_tick(slow_tick),
    .synch_en (synch_en),
    .decode_en(decode_en),
    .mult_en  (mult_en),
    .out_valid(out_valid),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  initial begin
    fast_clk = 1'b0;
    forever #5 fast_clk = ~fast_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic chk_cyc(input logic e_tick, input logic e_rdy, input logic e_shift,
                         input logic e_sy, input logic e_de, input logic e_mu,
                         input logic e_ov, input logic e_busy);
    chk("slow_tick", {31'd0, slow_tick}, {31'd0, e_tick});
    chk("in_ready",  {31'd0, in_ready},  {31'd0, e_rdy});
    chk("shift_en",  {31'd0, shift_en},  {31'd0, e_shift});
    chk("synch_en",  {31'd0, synch_en},  {31'd0, e_sy});
    chk("decode_en", {31'd0, decode_en}, {31'd0, e_de});
    chk("mult_en",   {31'd0, mult_en},   {31'd0, e_mu});
    chk("out_valid", {31'd0, out_valid}, {31'd0, e_ov});
    chk("busy",      {31'd0, busy},      {31'd0, e_busy});
  endtask

  task automatic chk_cnt(input logic [7:0] e_cnt);
    chk("done_cnt", {24'd0, done_cnt}, {24'd0, e_cnt});
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge fast_clk);
    #1;
    cyc_n++;
  endtask

  initial begin
    rst_n     = 1'b1;
    enable    = 1'b0;
    div_ratio = 4'd0;
    in_valid  = 1'b0;
    #1 rst_n  = 1'b0;
    #2;
    chk_cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk_cnt(8'd0);
    #20 rst_n = 1'b1;

    // Cycle 0: still IDLE, request run with ratio 3
    step();
    cyc_n     = 0;
    enable    = 1'b1;
    div_ratio = 4'd3;
    #1;
    chk_cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Cycles 1..8: empty pipeline, tick on every 4th cycle
    for (int i = 0; i < 8; i++) begin
      step();
      #1;
      chk_cyc(cyc_n % 4 == 0, 1, 0, 0, 0, 0, 0, 1);
    end
    chk_cnt(8'd0);

    // Cycles 9..20: single word accepted at count 0, reaches multiply on 3rd tick
    for (int i = 0; i < 12; i++) begin
      step();
      in_valid = (cyc_n == 9);
      #1;
      chk_cyc(cyc_n % 4 == 0, !(cyc_n == 10 || cyc_n == 11), cyc_n == 9,
              cyc_n == 12, cyc_n == 16, cyc_n == 20, 1'b0, 1);
    end

    // Cycles 21..52: in_valid held high for 8 periods
    for (int i = 0; i < 32; i++) begin
      step();
      in_valid = 1'b1;
      #1;
      if (cyc_n == 21) chk_cnt(8'd1);
      chk_cyc(cyc_n % 4 == 0, cyc_n == 21 || cyc_n % 4 == 0, cyc_n == 21 || cyc_n % 4 == 0,
              cyc_n % 4 == 0, cyc_n % 4 == 0 && cyc_n >= 28, cyc_n % 4 == 0 && cyc_n >= 32,
              cyc_n <= 24 || cyc_n >= 33, 1);
    end

    // Cycles 53..67: drop enable with 3 words in flight, drain to IDLE
    for (int i = 0; i < 15; i++) begin
      step();
      in_valid = 1'b0;
      enable   = (cyc_n == 67);
      #1;
      if (cyc_n == 53) chk_cnt(8'd7);
      if (cyc_n == 65) chk_cnt(8'd10);
      chk_cyc(cyc_n % 4 == 0 && cyc_n <= 64, 0, 0, cyc_n == 56,
              cyc_n == 56 || cyc_n == 60, cyc_n % 4 == 0 && cyc_n <= 64, 1, cyc_n <= 64);
    end

    // Cycles 68..82: ratio 3->1 at count 1, then 1->0
    for (int i = 0; i < 15; i++) begin
      step();
      if (cyc_n == 69) div_ratio = 4'd1;
      if (cyc_n == 78) div_ratio = 4'd0;
      #1;
      chk_cyc(cyc_n == 71 || (cyc_n > 71 && (cyc_n - 71) % 2 == 0) || cyc_n >= 79,
              1, 0, 0, 0, 0, cyc_n <= 71, 1);
    end

    // Cycles 83..86: ratio 0, one word walks a stage per cycle
    for (int i = 0; i < 4; i++) begin
      step();
      in_valid = (cyc_n == 83);
      #1;
      chk_cyc(1, 1, cyc_n == 83, cyc_n == 84, cyc_n == 85, cyc_n == 86, 0, 1);
    end
    chk_cnt(8'd10);

    // Asynchronous reset with a word in decode
    #1 rst_n = 1'b0;
    #1;
    chk_cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk_cnt(8'd0);
    #3 rst_n = 1'b1;
    enable   = 1'b0;

    // Cycles 87..92: restart, only a fresh word produces mult_en
    for (int i = 0; i < 6; i++) begin
      step();
      enable   = 1'b1;
      in_valid = (cyc_n == 88);
      #1;
      chk_cyc(cyc_n >= 88, cyc_n >= 88, cyc_n == 88, cyc_n == 89, cyc_n == 90,
              cyc_n == 91, cyc_n >= 92, cyc_n >= 88);
      if (cyc_n == 91) chk_cnt(8'd0);
      if (cyc_n == 92) chk_cnt(8'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
